// File: rtl/sram_access_sequencer.sv
// SRAM access sequencer: takes one read/write request at a time and splits the
// address into row and column fields. It then steps the array through
// precharge, wordline/column enable and sense, and returns one response per
// request. While the column decoder is enabled, it also encodes the one-hot
// column-select feedback back to binary and latches the first decode fault.
module sram_access_sequencer #(
  parameter int COL_ADDR_WIDTH   = 4,
  parameter int ROW_ADDR_WIDTH   = 4,
  parameter int NUM_COLS         = 16,
  parameter int DATA_WIDTH       = 8,
  parameter int PRECHARGE_CYCLES = 1,
  parameter int ACCESS_CYCLES    = 2,
  parameter int SENSE_CYCLES     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic                                   req_we,
  input  logic [ROW_ADDR_WIDTH+COL_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]                  req_wdata,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [DATA_WIDTH-1:0]                  rsp_rdata,
  output logic                                   rsp_we,
  output logic [ROW_ADDR_WIDTH-1:0]              row_addr,
  output logic [COL_ADDR_WIDTH-1:0]              col_addr,
  output logic                                   row_en,
  output logic                                   col_en,
  output logic                                   precharge,
  output logic                                   write_en,
  output logic [DATA_WIDTH-1:0]                  bl_wdata,
  output logic                                   sense_en,
  input  logic [DATA_WIDTH-1:0]                  sa_data,
  input  logic [NUM_COLS-1:0]                    col_sel_fb,
  output logic                                   decode_err,
  output logic [COL_ADDR_WIDTH-1:0]              err_col
);

  typedef enum logic [2:0] {IDLE, PRECHARGE, ACCESS, SENSE, RESPOND} state_t;

  // Phase lengths are at most 15, so a 4-bit down-counter covers every phase.
  localparam logic [3:0] PRE_LOAD = 4'(PRECHARGE_CYCLES - 1);
  localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] SEN_LOAD = 4'(SENSE_CYCLES - 1);
  localparam int         CNT_W    = $clog2(NUM_COLS + 1);

  state_t                    state;
  state_t                    state_next;
  logic [3:0]                phase_cnt;
  logic                      phase_done;
  logic                      accept;
  logic                      we_q;
  logic [CNT_W-1:0]          fb_count;
  logic [COL_ADDR_WIDTH-1:0] fb_index;
  logic                      fb_fault;

  // Gating with rst_n keeps req_ready low while reset is held, like every other output.
  assign req_ready  = rst_n && (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign phase_done = (phase_cnt == 4'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode: each timed phase exits when its counter reaches zero
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept)     state_next = PRECHARGE;
      PRECHARGE: if (phase_done) state_next = ACCESS;
      ACCESS:    if (phase_done) state_next = we_q ? RESPOND : SENSE;
      SENSE:     if (phase_done) state_next = RESPOND;
      RESPOND:   if (rsp_ready)  state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // Phase counter: reloaded on every state change, counts down inside a phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= 4'd0;
    end else if (state_next != state) begin
      case (state_next)
        PRECHARGE: phase_cnt <= PRE_LOAD;
        ACCESS:    phase_cnt <= ACC_LOAD;
        SENSE:     phase_cnt <= SEN_LOAD;
        default:   phase_cnt <= 4'd0;
      endcase
    end else if (!phase_done) begin
      phase_cnt <= phase_cnt - 4'd1;
    end
  end

  // Request capture, read-data capture and registered array controls
  // (the controls are decoded from the upcoming state, so they line up with it)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      row_addr  <= '0;
      col_addr  <= '0;
      bl_wdata  <= '0;
      rsp_rdata <= '0;
      rsp_we    <= 1'b0;
      rsp_valid <= 1'b0;
      precharge <= 1'b0;
      row_en    <= 1'b0;
      col_en    <= 1'b0;
      write_en  <= 1'b0;
      sense_en  <= 1'b0;
    end else begin
      if (accept) begin
        we_q      <= req_we;
        row_addr  <= req_addr[ROW_ADDR_WIDTH+COL_ADDR_WIDTH-1:COL_ADDR_WIDTH];
        col_addr  <= req_addr[COL_ADDR_WIDTH-1:0];
        bl_wdata  <= req_wdata;
        rsp_rdata <= '0;
      end else if (state == SENSE && phase_done) begin
        rsp_rdata <= sa_data;
      end
      precharge <= (state_next == PRECHARGE);
      row_en    <= (state_next == ACCESS) || (state_next == SENSE);
      col_en    <= (state_next == ACCESS) || (state_next == SENSE);
      write_en  <= (state_next == ACCESS) && we_q;
      sense_en  <= (state_next == SENSE);
      rsp_valid <= (state_next == RESPOND);
      rsp_we    <= (state_next == RESPOND) && we_q;
    end
  end

  // One-hot to binary encode of the decoder feedback, with a set-bit count
  always_comb begin
    fb_count = '0;
    fb_index = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (col_sel_fb[i]) begin
        fb_count = fb_count + CNT_W'(1);
        fb_index = fb_index | COL_ADDR_WIDTH'(i);
      end
    end
    fb_fault = (fb_count != CNT_W'(1)) || (fb_index != col_addr);
  end

  // Sticky decode fault: only the first fault while col_en is high is recorded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decode_err <= 1'b0;
      err_col    <= '0;
    end else if (col_en && fb_fault && !decode_err) begin
      decode_err <= 1'b1;
      err_col    <= col_addr;
    end
  end

endmodule
